// File: rtl/guess_game_ctrl_if.sv
// Handshake/bus bundle between the guess sequencer, the entry block and the display drivers.
interface guess_game_ctrl_if;
  logic       start;
  logic       enter;
  logic [7:0] guess;
  logic [1:0] hint;
  logic [3:0] attempts;
  logic [7:0] secret;
  logic       win;
  logic       lose;
  logic       busy;
  logic       clr_entry;

  modport master (
    output start, enter, guess,
    input  hint, attempts, secret, win, lose, busy, clr_entry
  );

  modport slave (
    input  start, enter, guess,
    output hint, attempts, secret, win, lose, busy, clr_entry
  );
endinterface

// File: rtl/guess_game_ctrl.sv
// Number guessing game sequencer: LFSR secret pick, edge-detected guesses, hints, WIN/LOSE.
// Optional GUESS_RANGE_CHECK_EN: out-of-range guesses clear the hint and cost no attempt.
module guess_game_ctrl #(
  parameter int unsigned MAX_VAL   = 99,
  parameter int unsigned MAX_TRIES = 7,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input logic              clk,
  input logic              rst,
  guess_game_ctrl_if.slave bus
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] MAX_V    = 8'(MAX_VAL);
  localparam logic [3:0] MAX_T    = 4'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PICK = 3'd1,
    WAIT = 3'd2,
    EVAL = 3'd3,
    WIN  = 3'd4,
    LOSE = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic [7:0] g_reg;
  logic       enter_d;
  logic       enter_rise;
  logic       lfsr_ok;
  logic [3:0] att_inc;
  logic [1:0] cmp_hint;

  assign enter_rise = bus.enter & ~enter_d;
  assign lfsr_ok    = (lfsr != 8'h00) && (lfsr <= MAX_V);
  // Saturating attempt counter value for the current evaluation
  assign att_inc    = (bus.attempts == MAX_T) ? MAX_T : bus.attempts + 4'd1;
  assign cmp_hint   = (g_reg == bus.secret) ? 2'b11 :
                      (g_reg <  bus.secret) ? 2'b01 : 2'b10;

`ifdef GUESS_RANGE_CHECK_EN
  logic g_oob;
  assign g_oob = (g_reg == 8'h00) || (g_reg > MAX_V);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= SEED_EFF;
      enter_d       <= 1'b0;
      g_reg         <= 8'h00;
      bus.hint      <= 2'b00;
      bus.attempts  <= 4'd0;
      bus.secret    <= 8'h00;
      bus.win       <= 1'b0;
      bus.lose      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.clr_entry <= 1'b0;
    end else begin
      lfsr          <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      enter_d       <= bus.enter;
      bus.clr_entry <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= PICK;
            bus.busy <= 1'b1;
          end
        end
        // Rejection sampling: wait for an LFSR value inside 1..MAX_VAL
        PICK: begin
          if (lfsr_ok) begin
            bus.secret   <= lfsr;
            bus.attempts <= 4'd0;
            bus.hint     <= 2'b00;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (enter_rise) begin
            g_reg         <= bus.guess;
            bus.clr_entry <= 1'b1;
            state         <= EVAL;
          end
        end
        EVAL: begin
`ifdef GUESS_RANGE_CHECK_EN
          if (g_oob) begin
            bus.hint <= 2'b00;
            state    <= WAIT;
          end else
`endif
          begin
            bus.hint     <= cmp_hint;
            bus.attempts <= att_inc;
            if (cmp_hint == 2'b11) begin
              state    <= WIN;
              bus.win  <= 1'b1;
              bus.busy <= 1'b0;
            end else if (att_inc == MAX_T) begin
              state    <= LOSE;
              bus.lose <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              state <= WAIT;
            end
          end
        end
        // Start wins over a simultaneous enter; the old round's results are cleared
        WIN, LOSE: begin
          if (bus.start) begin
            state        <= PICK;
            bus.win      <= 1'b0;
            bus.lose     <= 1'b0;
            bus.busy     <= 1'b1;
            bus.attempts <= 4'd0;
            bus.hint     <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Self-checking bench for guess_game_ctrl: vector table, corner sequences and random rounds.
module tb_guess_game_ctrl;

  localparam int unsigned MAX_VAL   = 99;
  localparam int unsigned MAX_TRIES = 3;
  localparam logic [7:0]  SEED      = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  guess_game_ctrl_if bus();

  guess_game_ctrl #(.MAX_VAL(MAX_VAL), .MAX_TRIES(MAX_TRIES), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference game state, tracked per round rather than per state
  logic [7:0] m_lfsr;
  logic [7:0] m_secret;
  int         m_att;
  logic [1:0] m_hint;
  bit         m_win, m_lose;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

  typedef struct {
    bit         use_secret;
    logic [7:0] g;
    logic [1:0] e_hint;
    logic [3:0] e_att;
    bit         e_win;
  } vec_t;
  vec_t tbl [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] outs();
    return {bus.hint, bus.attempts, bus.secret, bus.win, bus.lose, bus.busy, bus.clr_entry};
  endfunction

  task automatic model_eval(input logic [7:0] g);
    bit oob = 1'b0;
`ifdef GUESS_RANGE_CHECK_EN
    oob = (g == 8'd0) || (g > 8'(MAX_VAL));
`endif
    if (oob) begin
      m_hint = 2'b00;
    end else begin
      m_att++;
      m_hint = (g == m_secret) ? 2'b11 : (g < m_secret) ? 2'b01 : 2'b10;
      if (g == m_secret)           m_win  = 1'b1;
      else if (m_att == MAX_TRIES) m_lose = 1'b1;
    end
  endtask

  // Start a round from IDLE/WIN/LOSE and follow it through the secret pick
  task automatic do_start(input bit with_enter, input string tag);
    bit found = 1'b0;
    logic [7:0] exp_s = 8'h00;
    bus.start = 1'b1;
    if (with_enter) bus.enter = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.enter = 1'b0;
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_nowin"}, {bus.win, bus.lose, bus.clr_entry}, 0);
    for (int i = 0; i < 300; i++) begin
      if (m_lfsr >= 8'd1 && m_lfsr <= 8'(MAX_VAL)) begin
        exp_s = m_lfsr;
        found = 1'b1;
        tick();
        break;
      end
      tick();
    end
    if (!found) check({tag, "_pick_timeout"}, 0, 1);
    m_secret = exp_s;
    m_att = 0;
    m_hint = 2'b00;
    m_win = 1'b0;
    m_lose = 1'b0;
    check({tag, "_secret"}, bus.secret, exp_s);
    check({tag, "_clear"}, {bus.attempts, bus.hint}, 0);
  endtask

  // One guess: latch edge, then evaluation edge
  task automatic press(input logic [7:0] g, input string tag);
    logic [1:0] prev = m_hint;
    bus.guess = g;
    bus.enter = 1'b1;
    tick();
    check({tag, "_clr"}, bus.clr_entry, 1);
    check({tag, "_hold"}, bus.hint, prev);
    tick();
    bus.enter = 1'b0;
    model_eval(g);
    check({tag, "_clr_off"}, bus.clr_entry, 0);
    check({tag, "_hint"}, bus.hint, m_hint);
    check({tag, "_att"}, bus.attempts, m_att);
    check({tag, "_wl"}, {bus.win, bus.lose}, {m_win, m_lose});
    check({tag, "_busy"}, bus.busy, !(m_win || m_lose));
    tick();
  endtask

  initial begin
    logic [7:0] w;
    int pulses;

`ifdef GUESS_RANGE_CHECK_EN
    tbl[0] = '{1'b0, 8'd0,   2'b00, 4'd0, 1'b0};
    tbl[1] = '{1'b0, 8'd150, 2'b00, 4'd0, 1'b0};
    tbl[2] = '{1'b1, 8'd0,   2'b11, 4'd1, 1'b1};
`else
    tbl[0] = '{1'b0, 8'd0,   2'b01, 4'd1, 1'b0};
    tbl[1] = '{1'b0, 8'd150, 2'b10, 4'd2, 1'b0};
    tbl[2] = '{1'b1, 8'd0,   2'b11, 4'd3, 1'b1};
`endif

    bus.start = 1'b0;
    bus.enter = 1'b0;
    bus.guess = 8'h00;
    m_hint = 2'b00;
    repeat (3) tick();
    check("rst_outs", outs(), 0);
    check("rst_lfsr", dut.lfsr, 8'hA5);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_lfsr", dut.lfsr, m_lfsr);
      check("idle_outs", outs(), 0);
    end

    // Direct win on the first guess, then start + enter together in WIN
    do_start(1'b0, "r1");
    press(m_secret, "r1_win");
    bus.enter = 1'b1;
    tick();
    tick();
    bus.enter = 1'b0;
    tick();
    check("win_drop_enter", {bus.win, bus.attempts, bus.clr_entry}, {1'b1, 4'd1, 1'b0});
    do_start(1'b1, "r2");

    for (int i = 0; i < 3; i++) begin
      press(tbl[i].use_secret ? m_secret : tbl[i].g, "tbl");
      check("tbl_vec", {bus.hint, bus.attempts, bus.win},
            {tbl[i].e_hint, tbl[i].e_att, tbl[i].e_win});
    end

    // Lose after MAX_TRIES wrong in-range guesses; further enter ignored
    do_start(1'b0, "r3");
    w = (m_secret == 8'd1) ? 8'd2 : 8'd1;
    for (int i = 0; i < MAX_TRIES; i++) press(w, "lose");
    check("lose_flag", {bus.lose, bus.attempts}, {1'b1, 4'(MAX_TRIES)});
    bus.enter = 1'b1;
    tick();
    check("lose_noclr", bus.clr_entry, 0);
    tick();
    bus.enter = 1'b0;
    check("lose_hold", {bus.lose, bus.busy, bus.attempts}, {1'b1, 1'b0, 4'(MAX_TRIES)});
    tick();
    do_start(1'b0, "r4");

    // Enter held high: one guess only
    w = (m_secret == 8'd1) ? 8'd2 : 8'd1;
    bus.guess = w;
    bus.enter = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.clr_entry) pulses++;
    end
    model_eval(w);
    check("held_pulses", pulses, 1);
    check("held_att", bus.attempts, m_att);
    bus.enter = 1'b0;
    tick();

    // Reset during EVAL aborts the round
    bus.enter = 1'b1;
    tick();
    rst = 1'b1;
    bus.enter = 1'b0;
    tick();
    check("rst_eval_outs", outs(), 0);
    rst = 1'b0;
    tick();
    check("rst_eval_idle", outs(), 0);

    // Random rounds against the reference model
    for (int r = 0; r < 6; r++) begin
      do_start(1'b0, "rnd_start");
      for (int i = 0; i < 30 && !(m_win || m_lose); i++) begin
        repeat ($urandom_range(0, 3)) begin
          bus.start = 1'($urandom_range(0, 1));
          tick();
          check("rnd_busy", bus.busy, 1);
        end
        bus.start = 1'b0;
        if (i >= 25)                      w = m_secret;
        else if ($urandom_range(0, 1) == 0) w = 8'($urandom_range(1, MAX_VAL));
        else                              w = 8'($urandom_range(0, 255));
        press(w, "rnd");
      end
      check("rnd_done", m_win || m_lose, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
